// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED blink arbiter: FSM encoding and default widths.
package led_arb_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned CNT_W_DEF = 24;
    localparam int unsigned BLK_W_DEF = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t ON   = 2'd1;
    localparam state_t OFF  = 2'd2;
    localparam state_t DONE = 2'd3;

endpackage

// File: rtl/led_blink_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned j;

    always_comb begin : pick
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && req[IDX_W'(j)]) begin
                any              = 1'b1;
                idx              = IDX_W'(j);
                gnt[IDX_W'(j)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_blink_arbiter.sv
// Shares one LED among N_REQ requesters; each grant runs a latched blink burst
// to completion (or until its requester drops), owners chosen round-robin.
module led_blink_arbiter
    import led_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned BLK_W = BLK_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   half_period,
    input  logic [N_REQ*BLK_W-1:0]   n_blinks,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic                     led
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [CNT_W-1:0] hp_arr [N_REQ];
    logic [BLK_W-1:0] nb_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign hp_arr[g] = half_period[g*CNT_W +: CNT_W];
        assign nb_arr[g] = n_blinks[g*BLK_W +: BLK_W];
    end

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_gnt;
    logic             pick_any;
    logic [CNT_W-1:0] h_last;
    logic [CNT_W-1:0] phase;
    logic [BLK_W-1:0] blk;
    logic             zero_hold;
    logic [CNT_W-1:0] pick_h;
    logic [BLK_W-1:0] pick_b;
    logic             phase_end;
    logic             owner_req;
    logic [N_REQ-1:0] owner_oh;
    logic [N_REQ-1:0] sel_oh;

    logic             led_d;
    logic             busy_d;
    logic [N_REQ-1:0] grant_d;
    logic [N_REQ-1:0] done_d;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign pick_h    = hp_arr[pick_idx];
    assign pick_b    = nb_arr[pick_idx];
    assign phase_end = (phase == h_last);
    assign owner_req = req[owner];
    assign owner_oh  = N_REQ'(1) << owner;

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin : next_state_logic
        next_state = state;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    next_state = (pick_b == '0) ? DONE : ON;
                end
            end
            ON: begin
                if (!owner_req) begin
                    next_state = IDLE;
                end else if (phase_end) begin
                    next_state = OFF;
                end
            end
            OFF: begin
                if (!owner_req) begin
                    next_state = IDLE;
                end else if (phase_end) begin
                    next_state = (blk == BLK_W'(1)) ? DONE : ON;
                end
            end
            DONE: begin
                // A zero-blink burst spends its grant cycle here before the done cycle.
                if (!zero_hold) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin : output_logic
        led_d   = 1'b0;
        busy_d  = 1'b0;
        grant_d = '0;
        done_d  = '0;
        sel_oh  = (state == IDLE) ? pick_gnt : owner_oh;
        led_d   = (next_state == ON);
        busy_d  = (next_state != IDLE);
        if (next_state == ON || next_state == OFF ||
            (state == IDLE && next_state == DONE)) begin
            grant_d = sel_oh;
        end
        if (next_state == DONE && state != IDLE) begin
            done_d = sel_oh;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : output_reg
        if (rst) begin
            led   <= 1'b0;
            busy  <= 1'b0;
            grant <= '0;
            done  <= '0;
        end else begin
            led   <= led_d;
            busy  <= busy_d;
            grant <= grant_d;
            done  <= done_d;
        end
    end

    // Burst parameters are captured only at grant; H is stored as its last phase value.
    always_ff @(posedge clk or posedge rst) begin : datapath_reg
        if (rst) begin
            rr_ptr    <= '0;
            owner     <= '0;
            h_last    <= '0;
            blk       <= '0;
            phase     <= '0;
            zero_hold <= 1'b0;
        end else begin
            zero_hold <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner     <= pick_idx;
                        h_last    <= (pick_h == '0) ? '0 : pick_h - CNT_W'(1);
                        blk       <= pick_b;
                        phase     <= '0;
                        zero_hold <= (pick_b == '0);
                        rr_ptr    <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0
                                                                   : pick_idx + IDX_W'(1);
                    end
                end
                ON: begin
                    phase <= (next_state == ON) ? phase + CNT_W'(1) : '0;
                end
                OFF: begin
                    phase <= (next_state == OFF) ? phase + CNT_W'(1) : '0;
                    if (phase_end) begin
                        blk <= blk - BLK_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed self-checking bench for led_blink_arbiter with hand-computed expectations.
module tb_led_blink_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned CNT_W = 24;
    localparam int unsigned BLK_W = 4;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] half_period;
    logic [N_REQ*BLK_W-1:0] n_blinks;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic                   led;

    int n_checks;
    int n_fail;

    led_blink_arbiter #(
        .N_REQ (N_REQ),
        .CNT_W (CNT_W),
        .BLK_W (BLK_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .half_period (half_period),
        .n_blinks    (n_blinks),
        .grant       (grant),
        .done        (done),
        .busy        (busy),
        .led         (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input int h, input int b);
        half_period[i*CNT_W +: CNT_W] = CNT_W'(h);
        n_blinks[i*BLK_W +: BLK_W]    = BLK_W'(b);
    endtask

    // Sample n cycles of led (first cycle ends up most significant) and count cycles with grant==gmask.
    task automatic capture(input int n, input logic [N_REQ-1:0] gmask,
                           output logic [63:0] leds, output int gcnt);
        leds = '0;
        gcnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            leds = {leds[62:0], led};
            if (grant == gmask) gcnt++;
        end
    endtask

    logic [63:0] leds;
    int          gcnt;
    logic [3:0]  order [5];

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        req         = '0;
        half_period = '0;
        n_blinks    = '0;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        #12;
        check("rst_led",   64'(led),   64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        tick();
        rst = 1'b0;

        // Single burst H=3 B=2 on requester 0
        set_ch(0, 3, 2);
        req = 4'b0001;
        capture(12, 4'b0001, leds, gcnt);
        check("single_led_pattern", leds & 64'hFFF, 64'b111000111000);
        check("single_grant_cycles", 64'(gcnt), 64'd12);
        tick();
        check("single_done", 64'(done),  64'b0001);
        check("single_done_grant", 64'(grant), 64'd0);
        check("single_done_led", 64'(led), 64'd0);
        req = '0;
        tick();
        check("single_idle_busy", 64'(busy), 64'd0);
        check("single_idle_done", 64'(done), 64'd0);

        // Reset pointer to 0, then round-robin with all requesters held
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_ch(i, 1, 1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr%0d_grant_on", k), 64'(grant), 64'(order[k]));
            check($sformatf("rr%0d_led_on", k),   64'(led),   64'd1);
            tick();
            check($sformatf("rr%0d_grant_off", k), 64'(grant), 64'(order[k]));
            check($sformatf("rr%0d_led_off", k),   64'(led),   64'd0);
            tick();
            check($sformatf("rr%0d_done", k), 64'(done), 64'(order[k]));
            if (k == 4) req = '0;
            tick();
            check($sformatf("rr%0d_idle", k), 64'(busy), 64'd0);
        end

        // Zero blink count on requester 2
        set_ch(2, 5, 0);
        req = 4'b0100;
        tick();
        check("zb_grant", 64'(grant), 64'b0100);
        check("zb_led1",  64'(led),   64'd0);
        check("zb_done1", 64'(done),  64'd0);
        tick();
        check("zb_done",  64'(done),  64'b0100);
        check("zb_grant2", 64'(grant), 64'd0);
        check("zb_led2",  64'(led),   64'd0);
        req = '0;
        tick();
        check("zb_idle", 64'(busy), 64'd0);

        // Zero half-period behaves as one
        set_ch(3, 0, 1);
        req = 4'b1000;
        capture(2, 4'b1000, leds, gcnt);
        check("zh_led", leds & 64'h3, 64'b10);
        check("zh_grant_cycles", 64'(gcnt), 64'd2);
        tick();
        check("zh_done", 64'(done), 64'b1000);
        req = '0;
        tick();

        // Abort requester 1 in its second ON cycle; requester 3 follows
        set_ch(1, 4, 2);
        set_ch(3, 1, 1);
        req = 4'b0010;
        tick();
        check("ab_on1", 64'({grant, led}), 64'b00101);
        tick();
        check("ab_on2", 64'({grant, led}), 64'b00101);
        req = 4'b1000;
        tick();
        check("ab_drop", 64'({grant, led, busy}), 64'd0);
        check("ab_nodone", 64'(done), 64'd0);
        tick();
        check("ab_next_grant", 64'(grant), 64'b1000);
        tick();
        tick();
        check("ab_next_done", 64'(done), 64'b1000);
        req = '0;
        tick();

        // Half-period change mid-burst has no effect
        set_ch(0, 5, 1);
        req = 4'b0001;
        leds = '0;
        gcnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            leds = {leds[62:0], led};
            if (grant == 4'b0001) gcnt++;
            if (i == 1) set_ch(0, 2, 1);
        end
        check("latch_led", leds & 64'h3FF, 64'b1111100000);
        check("latch_grant_cycles", 64'(gcnt), 64'd10);
        tick();
        check("latch_done", 64'(done), 64'b0001);
        req = '0;
        tick();

        // Asynchronous reset during OFF
        set_ch(0, 3, 1);
        req = 4'b0001;
        for (int i = 0; i < 4; i++) tick();
        check("ar_pre_grant", 64'(grant), 64'b0001);
        check("ar_pre_busy",  64'(busy),  64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_led",   64'(led),   64'd0);
        check("ar_grant", 64'(grant), 64'd0);
        check("ar_busy",  64'(busy),  64'd0);
        rst = 1'b0;
        req = 4'b1010;
        tick();
        check("ar_first_grant", 64'(grant), 64'b0010);
        req = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
